// File: rtl/fops_pkg.sv
// Shared definitions for the bf16 float-ops unit (fadd / fmul / fdiv_seq).
package fops_pkg;

    localparam logic [15:0] BF16_QNAN = 16'h7FC0;
    localparam logic [15:0] BF16_INF  = 16'h7F80;
    localparam logic [15:0] BF16_ZERO = 16'h0000;
    localparam logic [9:0]  BF16_BIAS = 10'd127;

    // Quotient bits produced by the divider: 8 significand + guard + normalise slack.
    localparam int QBITS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2
    } fdiv_state_t;

    // Operand class; all flags clear means a normal number.
    typedef struct packed {
        logic zero;
        logic subnorm;
        logic inf;
        logic nan;
    } bf16_class_t;

    // Special-case outcome of a division, resolved when the operation starts.
    typedef enum logic [1:0] {
        SPC_NONE = 2'd0,
        SPC_QNAN = 2'd1,
        SPC_INF  = 2'd2,
        SPC_ZERO = 2'd3
    } fdiv_special_t;

    // Priority-ordered special decision; subnormal operands count as zero.
    function automatic fdiv_special_t fdiv_special(input bf16_class_t ca, input bf16_class_t cb);
        logic a_zero;
        logic b_zero;
        fdiv_special_t res;
        a_zero = ca.zero | ca.subnorm;
        b_zero = cb.zero | cb.subnorm;
        if (ca.nan || cb.nan) begin
            res = SPC_QNAN;
        end else if (a_zero && b_zero) begin
            res = SPC_QNAN;
        end else if (ca.inf && cb.inf) begin
            res = SPC_QNAN;
        end else if (ca.inf || b_zero) begin
            res = SPC_INF;
        end else if (cb.inf || a_zero) begin
            res = SPC_ZERO;
        end else begin
            res = SPC_NONE;
        end
        return res;
    endfunction

endpackage

// File: rtl/bf16_classify.sv
// Combinational classification of one bf16 operand (magnitude bits only).
module bf16_classify
    import fops_pkg::*;
(
    input  logic [14:0]  op_mag,
    output bf16_class_t  cls
);

    logic [7:0] exp_s;
    logic [6:0] frac_s;

    assign exp_s  = op_mag[14:7];
    assign frac_s = op_mag[6:0];

    // Decode exponent/fraction extremes into class flags.
    always_comb begin
        cls = '0;
        if (exp_s == 8'd0) begin
            cls.zero    = (frac_s == 7'd0);
            cls.subnorm = (frac_s != 7'd0);
        end else if (exp_s == 8'hFF) begin
            cls.inf = (frac_s == 7'd0);
            cls.nan = (frac_s != 7'd0);
        end else begin
            cls = '0;
        end
    end

endmodule

// File: rtl/fdiv_seq.sv
// Multi-cycle bf16 divider: radix-2 restoring mantissa division, one quotient
// bit per clock, fixed 11-edge latency from the accepting edge to done.
module fdiv_seq
    import fops_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    input  logic        round_to_zero,
    output logic        busy,
    output logic        done,
    output logic [15:0] result
);

    fdiv_state_t   state_q, state_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [15:0]   result_q, result_d;
    logic [3:0]    count_q, count_d;
    logic [8:0]    rem_q, rem_d;
    logic [9:0]    quo_q, quo_d;
    logic [7:0]    mb_q, mb_d;
    logic [7:0]    ea_q, ea_d;
    logic [7:0]    eb_q, eb_d;
    logic          sign_q, sign_d;
    logic          rtz_q, rtz_d;
    fdiv_special_t spc_q, spc_d;

    bf16_class_t   a_cls_s;
    bf16_class_t   b_cls_s;
    logic [7:0]    rem_diff_s;
    logic [15:0]   norm_result_s;

    bf16_classify u_cls_a (.op_mag(a_in[14:0]), .cls(a_cls_s));
    bf16_classify u_cls_b (.op_mag(b_in[14:0]), .cls(b_cls_s));

    // When a subtraction happens the true difference is below mb, so 8 bits suffice.
    assign rem_diff_s = rem_q[7:0] - mb_q;

    // Normalise the quotient, round, range-check and apply special overrides.
    always_comb begin
        logic [6:0]        mant_s;
        logic              guard_s;
        logic              guard_eff_s;
        logic [7:0]        mant_inc_s;
        logic [6:0]        mant_r_s;
        logic signed [9:0] exp_base_s;
        logic signed [9:0] exp_n_s;
        logic signed [9:0] exp_r_s;

        exp_base_s = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + $signed(BF16_BIAS);
        if (quo_q[9]) begin
            mant_s  = quo_q[8:2];
            guard_s = quo_q[1];
            exp_n_s = exp_base_s;
        end else begin
            mant_s  = quo_q[7:1];
            guard_s = quo_q[0];
            exp_n_s = exp_base_s - 10'sd1;
        end

        // Negative results truncate toward zero when requested; otherwise round half up.
        guard_eff_s = (rtz_q && sign_q) ? 1'b0 : guard_s;
        mant_inc_s  = {1'b0, mant_s} + {7'd0, guard_eff_s};
        if (mant_inc_s[7]) begin
            mant_r_s = 7'd0;
            exp_r_s  = exp_n_s + 10'sd1;
        end else begin
            mant_r_s = mant_inc_s[6:0];
            exp_r_s  = exp_n_s;
        end

        case (spc_q)
            SPC_QNAN: norm_result_s = BF16_QNAN;
            SPC_INF:  norm_result_s = BF16_INF;
            SPC_ZERO: norm_result_s = BF16_ZERO;
            default: begin
                if (exp_r_s >= 10'sd255) begin
                    norm_result_s = BF16_INF;
                end else if (exp_r_s <= 10'sd0) begin
                    norm_result_s = BF16_ZERO;
                end else begin
                    norm_result_s = {sign_q, exp_r_s[7:0], mant_r_s};
                end
            end
        endcase
    end

    // Next-state logic for the FSM, the iteration counter and the datapath.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        count_d  = count_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        mb_d     = mb_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        sign_d   = sign_q;
        rtz_d    = rtz_q;
        spc_d    = spc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d  = a_in[15] ^ b_in[15];
                    rtz_d   = round_to_zero;
                    ea_d    = a_in[14:7];
                    eb_d    = b_in[14:7];
                    rem_d   = {2'b01, a_in[6:0]};
                    mb_d    = {1'b1, b_in[6:0]};
                    quo_d   = 10'd0;
                    count_d = 4'd0;
                    spc_d   = fdiv_special(a_cls_s, b_cls_s);
                    busy_d  = 1'b1;
                    state_d = DIV;
                end else begin
                    state_d = IDLE;
                end
            end
            DIV: begin
                // Restoring step: subtract when it fits, then shift the remainder.
                if (rem_q >= {1'b0, mb_q}) begin
                    quo_d = {quo_q[8:0], 1'b1};
                    rem_d = {rem_diff_s, 1'b0};
                end else begin
                    quo_d = {quo_q[8:0], 1'b0};
                    rem_d = {rem_q[7:0], 1'b0};
                end
                count_d = count_q + 4'd1;
                if (count_q == 4'(QBITS - 1)) begin
                    state_d = NORM;
                end else begin
                    state_d = DIV;
                end
            end
            NORM: begin
                result_d = norm_result_s;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; async reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 16'h0000;
            count_q  <= 4'd0;
            rem_q    <= 9'd0;
            quo_q    <= 10'd0;
            mb_q     <= 8'd0;
            ea_q     <= 8'd0;
            eb_q     <= 8'd0;
            sign_q   <= 1'b0;
            rtz_q    <= 1'b0;
            spc_q    <= SPC_NONE;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            mb_q     <= mb_d;
            ea_q     <= ea_d;
            eb_q     <= eb_d;
            sign_q   <= sign_d;
            rtz_q    <= rtz_d;
            spc_q    <= spc_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: doc/fdiv_seq.md
Name: fdiv_seq

Overview:
- Multi-cycle bf16 divider, result = a_in / b_in; the inverse operation to the combinational bf16 multiplier in the float-ops unit.
- Radix-2 restoring mantissa division, one quotient bit per clock, with a start/busy/done handshake.
- Sits beside fadd/fmul in the execute stage. The core stalls on busy and takes the quotient on done.

Parameters:
- QBITS, 10, number of quotient bits generated (8 significand + guard + normalise slack); fixed, not for override.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- a_in  in  16  bf16 dividend
- b_in  in  16  bf16 divisor
- round_to_zero  in  1  1: truncate negative results; sampled with start
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse, result valid
- result  out  16  bf16 quotient, held until next done

Behaviour:
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, result=16'h0000, iteration count=0. Reset mid-operation aborts the operation with no done pulse.
- States are IDLE, DIV and NORM.
- IDLE: on a start=1 edge (call it T0), register the sign (a[15]^b[15]), round_to_zero, exponents, mantissas ma={1,a[6:0]} and mb={1,b[6:0]}, and the special class. Initialise remainder=ma and count=0. Go to DIV; busy=1.
- DIV: each edge, if rem>=mb then set the q bit to 1 and rem=rem-mb; then rem<<=1. The q bits shift in MSB-first. After 10 iterations (edges T1..T10), go to NORM.
- NORM: at edge T11, register result, done=1 for exactly the following cycle, busy=0, state back to IDLE.
- Latency is fixed at 11 edges from the accepting edge to the edge that asserts done, for all operand classes, including specials.
- start while busy=1 is ignored. start in the cycle done=1 is accepted, giving back-to-back issue.
- Normalisation, with q[9:0] = floor(ma*512/mb):
  - If q[9]=1: mant=q[8:2], guard=q[1], E=ea-eb+127.
  - Otherwise: mant=q[7:1], guard=q[0], E=ea-eb+126.
  - Exponent arithmetic is signed, 10 bits wide.
- Rounding:
  - Round-half-up: m8={1,mant}+guard. This is skipped (truncate) when round_to_zero=1 and sign=1.
  - If m8 carries to 9'h100, mant=0 and E=E+1.
- Range:
  - E>=255 gives 16'h7F80.
  - E<=0 gives 16'h0000 (flush; no subnormal output).
- Specials, decided at T0 and in priority order:
  - Either operand NaN (exp=255, frac!=0) gives 16'h7FC0.
  - 0/0 gives 16'h7FC0.
  - inf/inf gives 16'h7FC0.
  - a inf, or b zero, gives 16'h7F80.
  - b inf, or a zero, gives 16'h0000.
  - Subnormal inputs are treated as zero.
  - Sign is dropped on every special result, matching the fmul convention.
- Zero results are always +0.

Decomposition:
- Shared package fops_pkg:
  - BF16_QNAN=16'h7FC0, BF16_INF=16'h7F80, BF16_BIAS=127.
  - fdiv_state_t enum {IDLE, DIV, NORM}.
  - Operand-class typedef {zero, subnorm, inf, nan}.
- One natural sub-module, bf16_classify: combinational classification of one operand, instantiated twice. fadd/fmul can later reuse it.
- Datapath, counter and FSM stay in fdiv_seq.

Test Plan:
- 0x4040/0x4000, rtz=0 -> done exactly 11 edges after start, result 0x3FC0; busy high for edges T1..T11 only.
- 0x3F80/0x4040, rtz=0 -> 0x3EAB; 0xBF80/0x4040 with rtz=1 -> 0xBEAA, with rtz=0 -> 0xBEAB.
- Specials:
  - 0x3F80/0x0000 -> 0x7F80
  - 0x0000/0x0000 -> 0x7FC0
  - 0x0000/0x40A0 -> 0x0000
  - 0x7FC1/0x3F80 -> 0x7FC0
  - 0x7F80/0x7F80 -> 0x7FC0
- Range:
  - 0x7F00/0x3F00 -> 0x7F80 (overflow)
  - 0x0080/0x4000 -> 0x0000 (underflow flush)
  - 0x0040/0x3F80 -> 0x0000 (subnormal input)
- Handshake:
  - start held high through an operation -> second start ignored until done.
  - start asserted in the done cycle -> second result 11 edges later.
  - result stable between done pulses.
- Reset: rst_n low at T5 -> busy=0, done=0, result=0x0000 immediately (async), no done pulse; new op after release completes normally.
